// File: rtl/nios_system_sdram_onchip_bist_master.sv
// nios_system_sdram_onchip_bist_master
//   Purpose : Avalon-MM initiator that writes an additive pattern over a word
//             range of the on-chip RAM, reads it back, and counts mismatches.
//   Latency : start sampled at edge k -> N write cycles, N read cycles,
//             1 drain cycle, then a one-cycle done pulse (2N+1 cycles after
//             the first write). N=0 -> done in the cycle after start.
//   Backpressure: none; the slave accepts one access per cycle and returns
//             read data exactly one cycle after the address.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   start            single-cycle command, sampled only in IDLE
//   base_addr        first word address (latched on start)
//   word_count       number of words 0..2^ADDR_W (latched on start)
//   seed             pattern for word 0 (latched on start)
//   busy             high in WRITE, READ and DRAIN
//   done             one-cycle completion pulse
//   err_count        saturating mismatch count
//   first_err_addr   address of first mismatch, 0 if none
//   m_*              Avalon-MM master to the single-port RAM slave
//   inject_err       only with ONCHIP_BIST_ERR_INJECT_EN defined: corrupt
//                    bit 0 of word 0 on write (latched on start)
//
// Optional feature macro: ONCHIP_BIST_ERR_INJECT_EN

module nios_system_sdram_onchip_bist_master #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PAT_STEP = 32'h9E3779B9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
`ifdef ONCHIP_BIST_ERR_INJECT_EN
  input  logic              inject_err,
`endif
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  output logic              m_reset_req,
  input  logic [DATA_W-1:0] m_readdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  // Expected word and its address, delayed one cycle to line up with readdata.
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;

  logic [ADDR_W-1:0]   addr_cur;
  logic [ADDR_W:0]     cnt_m1;
  logic                last_word;
  logic [DATA_W-1:0]   inj_mask;

  // Word address wraps naturally at ADDR_W bits.
  assign addr_cur  = base_q + idx_q[ADDR_W-1:0];
  assign cnt_m1    = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (idx_q == cnt_m1);

`ifdef ONCHIP_BIST_ERR_INJECT_EN
  logic inj_q, inj_d;

  always_comb begin
    inj_mask = '0;
    if (state_q == ST_WRITE && inj_q && idx_q == '0) begin
      inj_mask = {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign inj_mask = '0;
`endif

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      pat_q      <= '0;
      exp_q      <= '0;
      cmp_addr_q <= '0;
      cmp_vld_q  <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      seed_q     <= seed_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

`ifdef ONCHIP_BIST_ERR_INJECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= inj_d;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    seed_d     = seed_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    cmp_addr_d = cmp_addr_q;
    cmp_vld_d  = 1'b0;
    err_d      = err_q;
    first_d    = first_q;
`ifdef ONCHIP_BIST_ERR_INJECT_EN
    inj_d      = inj_q;
`endif

    // Compare the read issued last cycle. err_q stays nonzero once an error
    // is seen (it saturates rather than wraps), so err_q==0 marks the first.
    if (cmp_vld_q && (m_readdata != exp_q)) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'd0) begin
        first_d = cmp_addr_q;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = word_count;
          seed_d  = seed;
          idx_d   = '0;
          pat_d   = seed;
          err_d   = '0;
          first_d = '0;
`ifdef ONCHIP_BIST_ERR_INJECT_EN
          inj_d   = inject_err;
`endif
          state_d = (word_count == '0) ? ST_DONE : ST_WRITE;
        end
      end

      ST_WRITE: begin
        idx_d = idx_q + {{ADDR_W{1'b0}}, 1'b1};
        pat_d = pat_q + PAT_STEP;
        if (last_word) begin
          idx_d   = '0;
          pat_d   = seed_q;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        cmp_vld_d  = 1'b1;
        exp_d      = pat_q;
        cmp_addr_d = addr_cur;
        idx_d      = idx_q + {{ADDR_W{1'b0}}, 1'b1};
        pat_d      = pat_q + PAT_STEP;
        if (last_word) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Final readdata compare happens here via cmp_vld_q.
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs: decoded from registered state so an async reset clears the
  // bus immediately. m_clken follows reset directly.
  // ------------------------------------------------------------------
  always_comb begin
    m_chipselect = (state_q == ST_WRITE) || (state_q == ST_READ);
    m_write      = (state_q == ST_WRITE);
    m_address    = m_chipselect ? addr_cur : '0;
    m_byteenable = m_chipselect ? 4'hF : 4'h0;
    m_writedata  = m_write ? (pat_q ^ inj_mask) : '0;
    busy         = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                   (state_q == ST_DRAIN);
    done         = (state_q == ST_DONE);
  end

  assign m_clken        = ~reset;
  assign m_reset_req    = 1'b0;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_nios_system_sdram_onchip_bist_master.sv
// Bench for nios_system_sdram_onchip_bist_master: a behavioural RAM slave,
// an expectation queue of bus operations and results filled when each run is
// issued, and a monitor that pops and compares whenever the DUT acts.
module tb_nios_system_sdram_onchip_bist_master;

  localparam logic [31:0] STEP = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic [31:0] seed = '0;
`ifdef ONCHIP_BIST_ERR_INJECT_EN
  logic        inject_err = 1'b0;
`endif
  logic        busy, done;
  logic [15:0] err_count;
  logic [9:0]  first_err_addr;
  logic [9:0]  m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken, m_reset_req;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;

  nios_system_sdram_onchip_bist_master dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
`ifdef ONCHIP_BIST_ERR_INJECT_EN
    .inject_err     (inject_err),
`endif
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .m_address      (m_address),
    .m_byteenable   (m_byteenable),
    .m_chipselect   (m_chipselect),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_clken        (m_clken),
    .m_reset_req    (m_reset_req),
    .m_readdata     (m_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural slave: 1024 x 32 RAM, one-cycle read latency, optional
  // readback fault flipping bit 7 of one address.
  logic [31:0] mem [0:1023];
  logic        fault_en = 1'b0;
  logic [9:0]  fault_addr = '0;

  always @(posedge clk) begin
    if (m_chipselect && m_write) mem[m_address] <= m_writedata;
    if (m_chipselect && !m_write)
      m_readdata <= mem[m_address] ^ ((fault_en && m_address == fault_addr) ? 32'h80 : 32'h0);
  end

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    int         done_cyc;
    int         errs;
    logic [9:0] first;
    int         busy_cycles;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t mon_b;
  res_t mon_r;
  int   busy_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      bus_q.delete();
      res_q.delete();
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (m_chipselect) begin
        if (bus_q.size() == 0) begin
          fail_evt("bus_op", "chipselect with no access expected");
        end else begin
          mon_b = bus_q.pop_front();
          chk("bus_write", 64'(m_write), 64'(mon_b.wr));
          chk("bus_addr", 64'(m_address), 64'(mon_b.addr));
          chk("bus_be", 64'(m_byteenable), 64'h0F);
          if (mon_b.wr) chk("bus_wdata", 64'(m_writedata), 64'(mon_b.data));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          fail_evt("done", "done pulse with no run outstanding");
        end else begin
          mon_r = res_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_r.done_cyc));
          chk("err_count", 64'(err_count), 64'(mon_r.errs));
          chk("first_err_addr", 64'(first_err_addr), 64'(mon_r.first));
          chk("busy_cycles", 64'(busy_cnt), 64'(mon_r.busy_cycles));
          chk("busy_at_done", 64'(busy), 64'h0);
          chk("clken_at_done", 64'(m_clken), 64'h1);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, m_chipselect, m_write, m_clken, m_reset_req}), 64'h0);
    chk({tag, "_addr"}, 64'({m_address, m_byteenable}), 64'h0);
    chk({tag, "_wdata"}, 64'(m_writedata), 64'h0);
    chk({tag, "_errs"}, 64'({err_count, first_err_addr}), 64'h0);
  endtask

  // Issue one run. Expected bus traffic and result come from plain
  // arithmetic: word i lives at (b+i) mod 1024 and holds s + i*STEP.
  task automatic run(input logic [9:0] b, input int n, input logic [31:0] s,
                     input logic fe, input logic [9:0] fa, input logic inj,
                     input int ign_at, input int abort_at);
    int         errs;
    logic [9:0] first;
    logic [9:0] a;
    logic [31:0] w;
    int         k;
    int         t;
    errs  = 0;
    first = '0;
    fault_en   = fe;
    fault_addr = fa;
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      w = s + 32'(i) * STEP;
      if (inj && i == 0) w = w ^ 32'h1;
      bus_q.push_back('{wr: 1'b1, addr: a, data: w});
    end
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      bus_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
      if ((inj && i == 0) || (fe && a == fa)) begin
        if (errs == 0) first = a;
        errs++;
      end
    end
    base_addr  = b;
    word_count = 11'(n);
    seed       = s;
`ifdef ONCHIP_BIST_ERR_INJECT_EN
    inject_err = inj;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    // Scramble inputs: the DUT must use its latched copies.
    base_addr  = 10'($urandom);
    word_count = 11'($urandom_range(1, 1024));
    seed       = $urandom;
`ifdef ONCHIP_BIST_ERR_INJECT_EN
    inject_err = ~inj;
`endif
    res_q.push_back('{done_cyc: (n == 0) ? k : k + 2*n + 1, errs: errs,
                      first: first, busy_cycles: (n == 0) ? 0 : 2*n + 1});
    if (ign_at > 0) begin
      repeat (ign_at) @(posedge clk);
      #1;
      start = 1'b1;
      word_count = 11'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("abort_rst");
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_clken", 64'(m_clken), 64'h1);
    end else begin
      t = 0;
      while (res_q.size() != 0 && t < 2*n + 40) begin
        @(posedge clk);
        t++;
      end
      #1;
      if (res_q.size() != 0) begin
        fail_evt("done_timeout", "no done pulse within cycle budget");
        res_q.delete();
      end
      chk("bus_drained", 64'(bus_q.size()), 64'h0);
      bus_q.delete();
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [9:0] rb;
    int         rn;
    logic       rfe;
    logic [9:0] rfa;
    logic       rinj;

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("por");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("clken_after_reset", 64'(m_clken), 64'h1);
    repeat (4) @(posedge clk);
    #1;

    // Basic pattern from seed 0.
    run(10'd0, 4, 32'h0, 1'b0, 10'd0, 1'b0, 0, 0);
    // Address wrap.
    run(10'd1022, 4, 32'h12345678, 1'b0, 10'd0, 1'b0, 0, 0);
    // Readback fault at address 5.
    run(10'd0, 8, 32'hCAFE0000, 1'b1, 10'd5, 1'b0, 0, 0);
    chk("err_hold", 64'({err_count, first_err_addr}), 64'({16'd1, 10'd5}));
    // Zero-length run.
    run(10'd77, 0, 32'h1, 1'b0, 10'd0, 1'b0, 0, 0);
    // Start during WRITE is ignored.
    run(10'd100, 16, 32'hA5A5A5A5, 1'b0, 10'd0, 1'b0, 3, 0);
    // Reset mid-READ, then a short run.
    run(10'd200, 10, 32'h0BADF00D, 1'b0, 10'd0, 1'b0, 0, 13);
    repeat (2) @(posedge clk);
    #1;
    run(10'd300, 2, 32'h00000001, 1'b0, 10'd0, 1'b0, 0, 0);
`ifdef ONCHIP_BIST_ERR_INJECT_EN
    run(10'd3, 4, 32'h55AA55AA, 1'b0, 10'd0, 1'b1, 0, 0);
`endif
    // Full-size run with a fault at the last word (which wraps).
    run(10'd512, 1024, 32'hDEADBEEF, 1'b1, 10'd511, 1'b0, 0, 0);

    // Randomised runs.
    for (int r = 0; r < 10; r++) begin
      rb  = 10'($urandom);
      rn  = $urandom_range(1, 40);
      rfe = 1'($urandom);
      rfa = ($urandom_range(0, 3) == 0) ? 10'($urandom) : rb + 10'($urandom_range(0, rn - 1));
`ifdef ONCHIP_BIST_ERR_INJECT_EN
      rinj = 1'($urandom);
`else
      rinj = 1'b0;
`endif
      run(rb, rn, $urandom, rfe, rfa, rinj, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
